// File: rtl/vlib_pipe_pkg.sv
// Shared helpers for the elastic pipeline library.
// clog2_occ(depth): number of bits needed to count 0..depth valid stages.
package vlib_pipe_pkg;

    function automatic int clog2_occ(input int depth);
        int w;
        w = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << w) < depth + 1) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data register.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   flush        - clears the valid bit at the next edge (data kept)
//   src_vld/data - valid bit and data of the stage feeding this one
//   adv          - this stage loads from its source this cycle
//   vld, data    - registered stage contents
module pipe_elastic_stage #(
    parameter int WID = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           src_vld,
    input  logic [WID-1:0] src_data,
    input  logic           adv,
    output logic           vld,
    output logic [WID-1:0] data
);

    logic           vld_d, vld_q;
    logic [WID-1:0] data_d, data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (adv) begin
            vld_d = src_vld;
            // Only valid data is ever captured, so bubbles never carry junk.
            if (src_vld) begin
                data_d = src_data;
            end
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_elastic.sv
// Elastic pipeline of DEPTH register stages with valid/ready handshakes on
// both sides, bubble collapsing, synchronous flush and a registered
// occupancy count.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   flush             - discard all in-flight entries at the next edge
//   in_vld/in_rdy     - upstream handshake, in_data is the payload
//   out_vld/out_rdy   - downstream handshake, out_data is the last stage
//   occ               - number of valid stages (registered)
module pipe_elastic
    import vlib_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WID   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [WID-1:0]                in_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [WID-1:0]                out_data,
    output logic [clog2_occ(DEPTH)-1:0]   occ
);

    localparam int OCC_W = clog2_occ(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_vld;
    logic [WID-1:0]   data     [DEPTH];
    logic [WID-1:0]   src_data [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_d, occ_q;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            // Stage i advances when any stage from i to the output is empty
            // or the output is draining: the unrolled form of the ready
            // chain, so a hole anywhere downstream pulls everything behind
            // it forward in the same cycle.
            assign adv[i] = out_rdy || !(&vld[DEPTH-1:i]);

            if (i == 0) begin : g_head
                assign src_vld[i]  = in_xfer;
                assign src_data[i] = in_data;
            end else begin : g_body
                assign src_vld[i]  = vld[i-1];
                assign src_data[i] = data[i-1];
            end

            pipe_elastic_stage #(
                .WID (WID)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .src_vld  (src_vld[i]),
                .src_data (src_data[i]),
                .adv      (adv[i]),
                .vld      (vld[i]),
                .data     (data[i])
            );
        end
    endgenerate

    assign in_rdy   = adv[0] && !flush;
    assign in_xfer  = in_vld && in_rdy;
    assign out_vld  = vld[DEPTH-1];
    assign out_data = data[DEPTH-1];
    assign out_xfer = out_vld && out_rdy;

    // Tracking transfers keeps occ equal to the popcount of the next valid
    // vector without a wide adder tree.
    always_comb begin
        occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

endmodule

// File: doc/pipe_elastic.md
PIPE_ELASTIC -- requirements
Module: pipe_elastic

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of register stages (legal range DEPTH >= 1).
REQ-002 The block SHALL have parameter WID, default 8, meaning the data width in bits (legal range WID >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge clocked.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit, a synchronous clear of all in-flight entries.
REQ-006 The block SHALL have port in_vld, input, 1 bit, upstream data valid.
REQ-007 The block SHALL have port in_rdy, output, 1 bit, block can accept in_data this cycle.
REQ-008 The block SHALL have port in_data, input, WID bits, upstream data.
REQ-009 The block SHALL have port out_vld, output, 1 bit, stage DEPTH-1 holds valid data.
REQ-010 The block SHALL have port out_rdy, input, 1 bit, downstream accepts out_data this cycle.
REQ-011 The block SHALL have port out_data, output, WID bits, data held in stage DEPTH-1.
REQ-012 The block SHALL have port occ, output, $clog2(DEPTH+1) bits, the count of valid stages.

Function
REQ-013 Each stage i SHALL hold a valid bit vld[i] and a WID-bit data register.
REQ-014 Stage i SHALL advance, meaning it loads from stage i-1 (or from in_data for i=0), when !vld[i] or stage i+1 advances; for stage DEPTH-1 the condition is !vld[DEPTH-1] or out_rdy.
REQ-015 The advance/ready chain SHALL be combinational, so that bubbles collapse: a gap in the pipe is filled in the same cycle that the stage behind it holds data.
REQ-016 in_rdy SHALL equal the stage-0 advance condition AND !flush.
REQ-017 A transfer SHALL occur on a cycle with in_vld && in_rdy (input side) or out_vld && out_rdy (output side).
REQ-018 Data SHALL leave in strict FIFO order, with no loss or duplication.
REQ-019 When a stage advances, its new valid bit SHALL be the valid bit of its source: vld[i-1], or in_vld && in_rdy for stage 0.
REQ-020 A stage that does not advance SHALL hold both its valid bit and its data unchanged.
REQ-021 The data register of a stage SHALL load only when that stage advances and its source is valid, so invalid data never propagates.
REQ-022 Latency with out_rdy=1 and no stalls SHALL be exactly DEPTH cycles from the accepting edge to out_vld=1.
REQ-023 Throughput with out_rdy=1 SHALL be one transfer per cycle.
REQ-024 With out_rdy=0, the block SHALL hold exactly DEPTH entries; after that, in_rdy=0 until an output transfer occurs.
REQ-025 When full, a cycle with a simultaneous output and input transfer SHALL accept the input in that same cycle, and occ SHALL stay at DEPTH.
REQ-026 occ SHALL equal the popcount of vld after every edge, and SHALL be registered.
REQ-027 flush=1 SHALL clear all vld bits at the next edge, set occ to 0, and accept no input that cycle.
REQ-028 Any output transfer in the flush cycle SHALL still complete, i.e. out_vld/out_data remain valid that cycle.
REQ-029 Data registers SHALL NOT be cleared by flush.
REQ-030 When DEPTH=1, the block SHALL degenerate to a single elastic register with the same rules.

Reset
REQ-031 While rst=1 at an edge, all vld bits and occ SHALL be set to 0, and all data registers to 0.
REQ-032 Therefore, after reset, out_vld=0, out_data=0 and occ=0, and in_rdy=1 once rst=0 and flush=0.
REQ-033 Reset SHALL take priority over flush and over all transfers; a reset mid-operation discards all entries.

Structure
REQ-034 The per-stage logic SHALL be one sub-module, pipe_elastic_stage (params WID), with ports clk, rst, flush, src_vld, src_data, adv, vld, data.
REQ-035 The top SHALL instantiate DEPTH copies of pipe_elastic_stage in a generate loop and compute the advance chain and occ.
REQ-036 A shared package vlib_pipe_pkg SHALL hold the function clog2_occ(DEPTH) used for the occ width; no typedefs are needed.

Verification
REQ-037 Reset and idle: DEPTH=4, WID=8; rst held 3 cycles, then released -> out_vld=0, out_data=0, occ=0, in_rdy=1.
REQ-038 Streaming: push 0x01..0x0A on consecutive cycles with out_rdy=1 -> 0x01 appears on out_data 4 cycles after its accept, then one value per cycle in order; occ peaks at 4.
REQ-039 Backpressure fill: out_rdy=0, push 0xA0..0xA5 -> only 0xA0..0xA3 accepted, in_rdy=0 from the 5th attempt, occ=4.
REQ-040 Full with simultaneous push/pop: then raise out_rdy for 1 cycle -> 0xA0 pops, 0xA4 is accepted in the same cycle, occ stays 4.
REQ-041 Bubble collapse: push 0x11, idle 2 cycles, push 0x22, with out_rdy=0 -> both are packed in stages 3 and 2 and occ=2; releasing out_rdy outputs 0x11 then 0x22 on consecutive cycles.
REQ-042 Flush mid-flight with 3 entries, flush=1 and in_vld=1 for one cycle -> in_rdy=0 that cycle, occ=0 and out_vld=0 on the next edge, and no value is later emitted.
